// File: rtl/cdc_hs_rx.sv
// Destination endpoint of a toggle-handshake CDC: captures the source's held data bus
// into a 2-entry valid/ready buffer and returns an acknowledge toggle.
module cdc_hs_rx #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_s,
  input  logic [W-1:0] in_data,
  output logic         ack_t,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  input  logic         out_rdy,
  output logic         busy
);

  typedef enum logic [0:0] {StIdle, StCapt} state_e;

  state_e       state_q, state_d;
  logic         ack_q;
  logic [W-1:0] mem_q [2];
  logic         wptr_q, rptr_q;
  logic [1:0]   count_q;

  logic pending, pop, space, wr;

  assign pending  = req_s ^ ack_q;
  assign out_vld  = (count_q != 2'd0);
  assign out_data = mem_q[rptr_q];
  assign pop      = out_vld & out_rdy;
  // A pop frees a slot in the same cycle, so a full buffer can still accept a write.
  assign space    = (count_q < 2'd2) | pop;
  assign ack_t    = ack_q;
  assign busy     = pending | (state_q == StCapt) | out_vld;

  // The extra CAPT cycle gives in_data one clk of settle time after req_s is seen.
  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    unique case (state_q)
      StIdle: if (pending) state_d = StCapt;
      StCapt: begin
        if (space) begin
          wr      = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ack_q    <= 1'b0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q <= state_d;
      if (wr) begin
        mem_q[wptr_q] <= in_data;
        wptr_q        <= ~wptr_q;
        ack_q         <= ~ack_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      count_q <= count_q + {1'b0, wr} - {1'b0, pop};
    end
  end

endmodule
